// File: rtl/rv_exec_unit.sv
// Multi-cycle RV32I execute/writeback unit: register file, ALU, branch compare and a
// handshaked data-memory port, sequenced IDLE -> EXEC -> (MEM) -> WB.
module rv_exec_unit #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int DM_ADDR_W = 5,
    localparam int RW = $clog2(REG_COUNT),
    localparam int SW = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [RW-1:0]        rs1,
    input  logic [RW-1:0]        rs2,
    input  logic [RW-1:0]        rd,
    input  logic [3:0]           alu_op,
    input  logic                 use_imm,
    input  logic [XLEN-1:0]      imm,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 load_byte,
    input  logic                 is_branch,
    input  logic [1:0]           br_type,
    input  logic                 is_lui,
    input  logic                 is_jal,
    input  logic [XLEN-1:0]      pc,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [XLEN-1:0]      dm_wdata,
    input  logic                 dm_ack,
    input  logic [XLEN-1:0]      dm_rdata,
    output logic                 wb_valid,
    output logic                 br_taken,
    output logic [XLEN-1:0]      br_target,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    state_t          state;
    logic [XLEN-1:0] rf [REG_COUNT];

    logic [RW-1:0]   rd_q;
    logic [3:0]      alu_op_q;
    logic [1:0]      br_type_q;
    logic            use_imm_q, load_byte_q, cond_q;
    logic            jal_q, lui_q, load_q, store_q, branch_q;
    logic [XLEN-1:0] imm_q, pc_q, a_q, b2_q, alu_q, ld_data_q, br_target_q;

    function automatic logic [XLEN-1:0] alu(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic [SW-1:0]          sh;
        sa = $signed(a);
        sh = b[SW-1:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return XLEN'(sa >>> sh);
            4'd8:    return XLEN'($signed(a) < $signed(b));
            4'd9:    return XLEN'(a < b);
            default: return '0;
        endcase
    endfunction

    function automatic logic br_cond(input logic [1:0] t,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        case (t)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return $signed(a) >= $signed(b);
            default: return $signed(a) < $signed(b);
        endcase
    endfunction

    function automatic logic [XLEN-1:0] sext_byte(input logic [XLEN-1:0] d);
        logic signed [7:0] b8;
        b8 = $signed(d[7:0]);
        return XLEN'(b8);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_q        <= '0;
            alu_op_q    <= '0;
            br_type_q   <= '0;
            use_imm_q   <= 1'b0;
            load_byte_q <= 1'b0;
            cond_q      <= 1'b0;
            jal_q       <= 1'b0;
            lui_q       <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            branch_q    <= 1'b0;
            imm_q       <= '0;
            pc_q        <= '0;
            a_q         <= '0;
            b2_q        <= '0;
            alu_q       <= '0;
            ld_data_q   <= '0;
            br_target_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    rd_q        <= rd;
                    alu_op_q    <= alu_op;
                    br_type_q   <= br_type;
                    use_imm_q   <= use_imm;
                    load_byte_q <= load_byte;
                    imm_q       <= imm;
                    pc_q        <= pc;
                    // Collapse overlapping flags to one: jal > lui > load > store > branch.
                    jal_q       <= is_jal;
                    lui_q       <= is_lui & ~is_jal;
                    load_q      <= is_load & ~is_jal & ~is_lui;
                    store_q     <= is_store & ~is_jal & ~is_lui & ~is_load;
                    branch_q    <= is_branch & ~is_jal & ~is_lui & ~is_load & ~is_store;
                    a_q         <= (rs1 == '0) ? '0 : rf[rs1];
                    b2_q        <= (rs2 == '0) ? '0 : rf[rs2];
                    state       <= EXEC;
                end
                EXEC: begin
                    alu_q       <= alu(alu_op_q, a_q, use_imm_q ? imm_q : b2_q);
                    cond_q      <= br_cond(br_type_q, a_q, b2_q);
                    br_target_q <= pc_q + imm_q;
                    state       <= (load_q | store_q) ? MEM : WB;
                end
                MEM: if (dm_ack) begin
                    if (load_q) ld_data_q <= load_byte_q ? sext_byte(dm_rdata) : dm_rdata;
                    state <= WB;
                end
                WB: begin
                    if (rd_q != '0) begin
                        if (jal_q)                    rf[rd_q] <= pc_q + XLEN'(4);
                        else if (lui_q)               rf[rd_q] <= imm_q;
                        else if (load_q)              rf[rd_q] <= ld_data_q;
                        else if (!store_q && !branch_q) rf[rd_q] <= alu_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign op_ready  = (state == IDLE);
    assign busy      = ~op_ready;
    assign dm_req    = (state == MEM);
    assign dm_we     = dm_req & store_q;
    assign dm_addr   = alu_q[DM_ADDR_W-1:0];
    assign dm_wdata  = b2_q;
    assign wb_valid  = (state == WB);
    assign br_taken  = wb_valid & (jal_q | (branch_q & cond_q));
    assign br_target = br_target_q;

endmodule

// File: tb/tb_rv_exec_unit.sv
// Bench for rv_exec_unit: directed and random operations against a register-array model,
// plus a 16-bit/8-register instance for back-pressure and reset-during-MEM.
module tb_rv_exec_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 32-bit instance
    logic        reset = 1'b0, op_valid = 1'b0, op_ready, busy;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [3:0]  alu_op = '0;
    logic        use_imm = 0, is_load = 0, is_store = 0, load_byte = 0, is_branch = 0, is_lui = 0, is_jal = 0;
    logic [1:0]  br_type = '0;
    logic [31:0] imm = '0, pc = '0, dm_rdata = '0, dm_wdata, br_target;
    logic        dm_req, dm_we, dm_ack = 1'b0, wb_valid, br_taken;
    logic [4:0]  dm_addr;

    rv_exec_unit #(.XLEN(32), .REG_COUNT(32), .DM_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .use_imm(use_imm), .imm(imm),
        .is_load(is_load), .is_store(is_store), .load_byte(load_byte), .is_branch(is_branch),
        .br_type(br_type), .is_lui(is_lui), .is_jal(is_jal), .pc(pc),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid), .br_taken(br_taken),
        .br_target(br_target), .busy(busy));

    // 16-bit, 8-register instance
    logic        reset_s = 1'b0, op_valid_s = 1'b0, op_ready_s, busy_s;
    logic [2:0]  rs1_s = '0, rs2_s = '0, rd_s = '0;
    logic [3:0]  alu_op_s = '0;
    logic        use_imm_s = 0, is_load_s = 0, is_store_s = 0, is_lui_s = 0;
    logic [15:0] imm_s = '0, dm_wdata_s, br_target_s;
    logic        dm_req_s, dm_we_s, dm_ack_s = 1'b0, wb_valid_s, br_taken_s;
    logic [4:0]  dm_addr_s;

    rv_exec_unit #(.XLEN(16), .REG_COUNT(8), .DM_ADDR_W(5)) dut_s (
        .clk(clk), .reset(reset_s), .op_valid(op_valid_s), .op_ready(op_ready_s),
        .rs1(rs1_s), .rs2(rs2_s), .rd(rd_s), .alu_op(alu_op_s), .use_imm(use_imm_s), .imm(imm_s),
        .is_load(is_load_s), .is_store(is_store_s), .load_byte(1'b0), .is_branch(1'b0),
        .br_type(2'd0), .is_lui(is_lui_s), .is_jal(1'b0), .pc(16'h0),
        .dm_req(dm_req_s), .dm_we(dm_we_s), .dm_addr(dm_addr_s), .dm_wdata(dm_wdata_s),
        .dm_ack(dm_ack_s), .dm_rdata(16'h0), .wb_valid(wb_valid_s), .br_taken(br_taken_s),
        .br_target(br_target_s), .busy(busy_s));

    logic [31:0] m_rf [32];
    int          obs_lat, obs_mem;
    logic [31:0] obs_addr, obs_wdata, obs_target;
    logic        obs_we, obs_taken, obs_stable;
    int          s_lat;
    logic [15:0] s_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b & 32'd31);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_br(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        case (t)
            0: return a == b;
            1: return a != b;
            2: return int'(a) >= int'(b);
            default: return int'(a) < int'(b);
        endcase
    endfunction

    task automatic clr();
        rs1 = 0; rs2 = 0; rd = 0; alu_op = 0; use_imm = 0; imm = 0; pc = 0; br_type = 0;
        is_load = 0; is_store = 0; load_byte = 0; is_branch = 0; is_lui = 0; is_jal = 0;
    endtask

    // Issue the staged operation and follow it to retirement, acking MEM in its memc-th cycle.
    task automatic do_op(input int memc, input logic [31:0] rdata);
        int cyc;
        bit done;
        cyc = 0; done = 0; obs_mem = 0; obs_stable = 1; obs_taken = 0; obs_target = 0;
        obs_we = 0; obs_addr = 0; obs_wdata = 0;
        chk("op_ready_before_issue", op_ready, 1);
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        while (!done && cyc < 60) begin
            cyc++;
            if (dm_req) begin
                if (obs_mem == 0) begin
                    obs_addr = dm_addr; obs_we = dm_we; obs_wdata = dm_wdata;
                end else if (dm_addr !== obs_addr[4:0] || dm_we !== obs_we || dm_wdata !== obs_wdata) begin
                    obs_stable = 0;
                end
                obs_mem++;
                dm_ack = (obs_mem >= memc);
                dm_rdata = rdata;
            end else begin
                dm_ack = 1'b0;
            end
            if (wb_valid) begin
                done = 1; obs_taken = br_taken; obs_target = br_target;
            end
            @(posedge clk); #1;
        end
        dm_ack = 1'b0;
        obs_lat = cyc;
        chk("retire_within_budget", done, 1);
    endtask

    task automatic model_op(input int memc, input logic [31:0] rdata);
        logic [31:0] a, b2, res, wv;
        bit jal, lui, ld, st, br, mem, tk, wr;
        a = m_rf[rs1]; b2 = m_rf[rs2];
        res = m_alu(alu_op, a, use_imm ? imm : b2);
        jal = is_jal;
        lui = is_lui && !jal;
        ld  = is_load && !jal && !lui;
        st  = is_store && !jal && !lui && !ld;
        br  = is_branch && !jal && !lui && !ld && !st;
        mem = ld || st;
        do_op(memc, rdata);
        chk("latency", obs_lat, mem ? memc + 2 : 2);
        chk("mem_cycles", obs_mem, mem ? memc : 0);
        if (mem) begin
            chk("dm_addr", obs_addr, res & 32'd31);
            chk("dm_we", obs_we, st);
            chk("dm_stable", obs_stable, 1);
            if (st) chk("dm_wdata", obs_wdata, b2);
        end
        tk = jal || (br && m_br(br_type, a, b2));
        chk("br_taken", obs_taken, tk);
        if (tk) chk("br_target", obs_target, pc + imm);
        wr = 1;
        if (jal)      wv = pc + 4;
        else if (lui) wv = imm;
        else if (ld)  wv = load_byte ? {{24{rdata[7]}}, rdata[7:0]} : rdata;
        else begin    wv = res; wr = !st && !br; end
        if (wr && rd != 0) m_rf[rd] = wv;
    endtask

    task automatic set_lui(input logic [4:0] r, input logic [31:0] v);
        clr(); is_lui = 1; rd = r; imm = v;
        model_op(1, 0);
    endtask

    task automatic do_alu(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic ui, input logic [31:0] iv);
        clr(); alu_op = op; rd = d; rs1 = s1; rs2 = s2; use_imm = ui; imm = iv;
        model_op(1, 0);
    endtask

    task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        clr(); is_store = 1; rs2 = r;
        do_op(1, 0);
        chk(tag, obs_wdata, exp);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_op_ready", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dm_req", dm_req, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_dm_wdata", dm_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_br_taken", br_taken, 0);
        chk("rst_br_target", br_target, 0);
    endtask

    task automatic do_op_s(input int memc);
        int cyc;
        bit done;
        cyc = 0; done = 0; s_wdata = 0;
        op_valid_s = 1'b1;
        @(posedge clk); #1;
        op_valid_s = 1'b0;
        while (!done && cyc < 60) begin
            cyc++;
            if (dm_req_s) begin s_wdata = dm_wdata_s; dm_ack_s = (cyc >= memc + 1); end
            else dm_ack_s = 1'b0;
            if (wb_valid_s) done = 1;
            @(posedge clk); #1;
        end
        dm_ack_s = 1'b0;
        s_lat = cyc;
        chk("s_retire_within_budget", done, 1);
    endtask

    initial begin
        int acc, wbs;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset = 1'b1; reset_s = 1'b1;
        @(posedge clk); #1;

        // ALU boundary cases
        set_lui(1, 32'h8000_0000);
        set_lui(2, 32'h0000_0004);
        do_alu(7, 6, 1, 2, 0, 0);
        do_alu(6, 7, 1, 2, 0, 0);
        do_alu(8, 8, 1, 2, 0, 0);
        do_alu(9, 9, 1, 2, 0, 0);
        do_alu(1, 10, 2, 1, 0, 0);
        read_reg("sra", 6, 32'hF800_0000);
        read_reg("srl", 7, 32'h0800_0000);
        read_reg("slt", 8, 32'h1);
        read_reg("sltu", 9, 32'h0);
        read_reg("sub", 10, 32'h8000_0004);

        // Load byte with 3 MEM cycles
        set_lui(3, 32'd7);
        clr(); is_load = 1; load_byte = 1; rd = 4; rs1 = 3; imm = 1; use_imm = 1;
        model_op(3, 32'h0000_00F0);
        chk("load_addr", obs_addr, 8);
        chk("load_mem_cycles", obs_mem, 3);
        read_reg("load_byte_sext", 4, 32'hFFFF_FFF0);

        // Zero-wait store
        set_lui(5, 32'hDEAD_BEEF);
        clr(); is_store = 1; rs2 = 5; rd = 6;
        model_op(1, 0);
        chk("store_we", obs_we, 1);
        chk("store_wdata", obs_wdata, 32'hDEAD_BEEF);
        chk("store_one_mem_cycle", obs_mem, 1);
        read_reg("store_no_write", 6, 32'hF800_0000);

        // Branches and JAL
        set_lui(1, 32'hFFFF_FFFF);
        set_lui(2, 32'h1);
        clr(); is_branch = 1; br_type = 3; rs1 = 1; rs2 = 2; pc = 32'h100; imm = 32'h20;
        model_op(1, 0);
        chk("blt_taken", obs_taken, 1);
        chk("blt_target", obs_target, 32'h120);
        clr(); is_branch = 1; br_type = 1; rs1 = 2; rs2 = 2; pc = 32'h100; imm = 32'h20;
        model_op(1, 0);
        chk("bne_not_taken", obs_taken, 0);
        clr(); is_jal = 1; rd = 1; pc = 32'h100; imm = 32'h20;
        model_op(1, 0);
        chk("jal_taken", obs_taken, 1);
        read_reg("jal_link", 1, 32'h104);

        // Conflicting flags: jal wins, no memory access
        clr(); is_jal = 1; is_load = 1; is_store = 1; rd = 11; pc = 32'h40; imm = 32'h8;
        model_op(2, 32'h1234);
        chk("prio_no_mem", obs_mem, 0);

        // Random operations against the model
        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(0, 10);
            clr();
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); alu_op = 4'($urandom);
            use_imm = 1'($urandom); imm = $urandom; pc = 32'($urandom_range(0, 1023)) << 2;
            br_type = 2'($urandom); load_byte = 1'($urandom);
            case (k)
                5:  is_lui = 1;
                6:  is_jal = 1;
                7:  is_branch = 1;
                8:  is_load = 1;
                9:  is_store = 1;
                10: {is_jal, is_lui, is_load, is_store, is_branch} = 5'($urandom);
                default: ;
            endcase
            model_op($urandom_range(1, 4), $urandom);
        end
        for (int r = 0; r < 32; r++) read_reg($sformatf("rf_x%0d", r), 5'(r), m_rf[r]);

        // Reset while in MEM
        clr(); is_load = 1; rd = 5; imm = 3; use_imm = 1;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        chk("mem_req_before_reset", dm_req, 1);
        #2 reset = 1'b0;
        #1 chk_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        wbs = 0;
        repeat (4) begin
            if (wb_valid) wbs++;
            @(posedge clk); #1;
        end
        chk("no_wb_after_reset", wbs, 0);
        read_reg("rf_cleared", 5, 32'h0);
        do_alu(0, 0, 0, 0, 1, 32'd5);
        read_reg("x0_zero", 0, 32'h0);

        // 16-bit instance: op_valid held high while busy
        rd_s = 2; use_imm_s = 1; imm_s = 16'h1234;
        op_valid_s = 1'b1;
        acc = 0; wbs = 0;
        for (int i = 0; i < 9; i++) begin
            if (op_ready_s) acc++;
            if (wb_valid_s) wbs++;
            @(posedge clk); #1;
        end
        op_valid_s = 1'b0;
        chk("s_accepts", acc, 3);
        chk("s_retires", wbs, 3);
        use_imm_s = 0; is_lui_s = 1; rd_s = 1; imm_s = 16'h8000;
        do_op_s(1);
        chk("s_latency", s_lat, 2);
        is_lui_s = 0; use_imm_s = 1; alu_op_s = 7; rd_s = 3; rs1_s = 1; imm_s = 16'h0014;
        do_op_s(1);
        use_imm_s = 0; alu_op_s = 0; is_store_s = 1; rs2_s = 3; rd_s = 0;
        do_op_s(1);
        chk("s_sra_masked", s_wdata, 16'hF800);
        chk("s_store_latency", s_lat, 3);
        rs2_s = 2;
        do_op_s(1);
        chk("s_held_add", s_wdata, 16'h1234);

        // 16-bit instance: reset while in MEM
        is_store_s = 0; is_load_s = 1; rd_s = 2; rs1_s = 0; use_imm_s = 1; imm_s = 16'h2;
        op_valid_s = 1'b1;
        @(posedge clk); #1;
        op_valid_s = 1'b0;
        @(posedge clk); #1;
        chk("s_req_before_reset", dm_req_s, 1);
        #2 reset_s = 1'b0;
        #1 chk("s_req_drops_async", dm_req_s, 0);
        @(posedge clk); #1;
        reset_s = 1'b1;
        wbs = 0;
        repeat (5) begin
            if (wb_valid_s) wbs++;
            @(posedge clk); #1;
        end
        chk("s_no_wb_after_reset", wbs, 0);
        is_load_s = 0; is_store_s = 1; rs2_s = 2; use_imm_s = 0; imm_s = 0;
        do_op_s(1);
        chk("s_rf_cleared", s_wdata, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_exec_unit.md
# rv_exec_unit

Parametrised multi-cycle execute/writeback unit for the RV32I microcontroller core, the successor to the single-cycle datapath. It owns the register file, ALU, branch comparator and a handshaked data-memory port, and sequences each decoded operation through an accept/execute/memory/writeback state machine. It sits between the decoder/control unit, which presents one decoded operation at a time, and the data memory.

## Interface
- XLEN, 32: datapath width; must be a power of two and at least 8.
- REG_COUNT, 32: number of architectural registers; x0 is hardwired to zero.
- DM_ADDR_W, 5: data-memory word-address width.
- RW = $clog2(REG_COUNT), SW = $clog2(XLEN): derived localparams.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- op_valid  in  1  decoded operation present.
- op_ready  out  1  unit can accept an operation (high only in IDLE).
- rs1, rs2, rd  in  RW  source and destination register numbers.
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10–15 produce 0.
- use_imm  in  1  ALU operand B is imm instead of R[rs2].
- imm  in  XLEN  sign-extended immediate; for LUI it is already shifted.
- is_load, is_store, load_byte  in  1  memory op; load_byte sign-extends dm_rdata[7:0].
- is_branch  in  1  conditional branch; br_type selects the condition.
- br_type  in  2  0 EQ, 1 NE, 2 GE (signed), 3 LT (signed).
- is_lui, is_jal  in  1  LUI, or jump-and-link.
- pc  in  XLEN  PC of the operation.
- dm_req  out  1  memory request, held until acknowledged.
- dm_we  out  1  store when 1.
- dm_addr  out  DM_ADDR_W  equals alu_result[DM_ADDR_W-1:0].
- dm_wdata  out  XLEN  R[rs2] captured at accept.
- dm_ack  in  1  memory done; on loads dm_rdata is valid in the same cycle.
- dm_rdata  in  XLEN  load data.
- wb_valid  out  1  one-cycle pulse when an operation retires.
- br_taken  out  1  valid with wb_valid.
- br_target  out  XLEN  pc+imm, valid with br_taken.
- busy  out  1  equals ~op_ready.

## Operation
- **Accept:** in IDLE with op_valid=1, all operation fields are registered and R[rs1] and R[rs2] are read. R[x0] always reads 0.
- **States:**
  - IDLE → EXEC on accept.
  - EXEC → MEM if is_load or is_store, else → WB.
  - MEM → WB on dm_ack.
  - WB → IDLE unconditionally.
  - Unreachable encodings return to IDLE.
- **EXEC:** registers alu_result (A = R[rs1], B = imm or R[rs2]) and the branch condition.
  - Shifts use B[SW-1:0].
  - SLT is signed and SLTU is unsigned; both produce 0 or 1.
  - Arithmetic wraps modulo 2^XLEN.
- **MEM:**
  - dm_req=1; dm_we, dm_addr and dm_wdata are stable while dm_req is high.
  - Loads capture dm_rdata on dm_ack.
  - dm_ack in any other state is ignored.
- **WB writes rd (if rd ≠ 0), by priority:**
  1. is_jal: pc+4.
  2. is_lui: imm.
  3. is_load: load data.
  4. Otherwise: alu_result if not store/branch.
- Stores and branches write no register.
- **Branch outputs in WB:** br_taken = is_jal or (is_branch and condition true); br_target = pc+imm.
- Flags are decoded exclusively; if more than one is set, the priority jal > lui > load > store > branch > ALU applies.
- **Reset:**
  - State goes to IDLE and every register, including the whole register file, goes to 0.
  - Outputs at reset: op_ready=1, busy=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, wb_valid=0, br_taken=0, br_target=0.
  - Reset asserted mid-MEM drops dm_req asynchronously; the operation is lost.

## Timing
- **Latency** from accept edge t: non-memory ops give wb_valid in cycle t+2; memory ops give wb_valid one cycle after the dm_ack cycle.
- **Throughput:** at most one operation per 3 cycles.
- The register write occurs at the end of the WB cycle. An operation accepted in the cycle after WB reads the new value; no forwarding is needed.
- op_ready is low from t+1 through WB inclusive. op_valid during busy is ignored, and the decoder must hold it.
- dm_req rises the cycle after EXEC. A zero-wait memory may assert dm_ack in the first MEM cycle, so MEM can last 1 cycle.
- There is no MEM timeout; the unit waits for dm_ack indefinitely.

## Test plan
- **Reset and x0:**
  - Stimulus: reset low mid-operation, then released; then ADD rd=0, rs1=0, imm=5, use_imm.
  - Response: all outputs at reset values; op_ready=1; R0 still reads 0.
- **ALU ops:**
  - Stimulus: R1=0x80000000, R2=4 (XLEN=32).
  - Response: SRA → 0xF8000000, SRL → 0x08000000, SLT R1,R2 → 1, SLTU → 0, SUB R2,R1 → 0x80000004; wb_valid two cycles after each accept.
- **Load with wait states:**
  - Stimulus: R3=7, load_byte, imm=1; dm_ack after 3 cycles with dm_rdata=0x000000F0.
  - Response: dm_addr=8, dm_req stable for 3 cycles, R4=0xFFFFFFF0.
- **Store:**
  - Stimulus: store R5=0xDEADBEEF with zero-wait ack.
  - Response: dm_we=1, dm_wdata=0xDEADBEEF, MEM lasts 1 cycle, no register change.
- **Branches and JAL:**
  - Stimulus: pc=0x100, imm=0x20; BLT with R1=-1, R2=1; BNE with equal operands; JAL rd=1.
  - Response: BLT gives br_taken=1, br_target=0x120; BNE gives br_taken=0; JAL gives R1=0x104, br_taken=1.
- **Parametrisation and back-pressure:**
  - Stimulus: XLEN=16, REG_COUNT=8; op_valid held high while busy; reset pulse during MEM.
  - Response: exactly one accept per operation; dm_req drops immediately on reset; no wb_valid pulse follows.
